instr_fetch: RTL and testbench
==============================

# instr_fetch

Multicycle instruction fetch unit: holds the PC, runs the fetch handshake against instruction memory, latches the instruction register (IR), and presents the decoded fields that feed the immediate/zero extenders and the jump-target concatenator directly downstream. It is driven by the multicycle control unit: one `fetch_start` per instruction, and one PC write per branch or jump. It also detects misaligned PCs and memory timeouts.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value after reset.
- `TIMEOUT`, 16, max cycles `imem_req` may stay high without `imem_ready` (≥1).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_start` in 1: control requests fetch at the current PC.
- `pc_we` in 1: control writes `pc_next` into the PC.
- `pc_next` in 32: branch/jump target.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 32: fetch address, stable while `imem_req` is high.
- `imem_rdata` in 32: instruction word, valid with `imem_ready`.
- `imem_ready` in 1: memory completion, sampled only while `imem_req` is high.
- `pc` out 32: current PC register.
- `pc_plus4` out 32: `pc + 4`, combinational.
- `ir` out 32: instruction register.
- `ir_valid` out 1: `ir` holds the most recently requested instruction.
- `fetch_done` out 1: single-cycle pulse when the IR is loaded.
- `op`, `func` out 6 each: `ir[31:26]` and `ir[5:0]`.
- `rs`, `rt`, `rd`, `shamt` out 5 each: `ir[25:21]`, `ir[20:16]`, `ir[15:11]`, `ir[10:6]`.
- `imm16` out 16: `ir[15:0]`, goes to the extender input.
- `index26` out 26: `ir[25:0]`, goes to the jump concatenator's low input.
- `pc_hi4` out 4: `pc[31:28]`, goes to the jump concatenator's high input.
- `imm_signed` out 1: the extender's S select.
- `err` out 1: sticky fault flag.
- `err_code` out 2: 0 none, 1 misaligned PC, 2 timeout.

## Operation
- States: IDLE, FETCH, ERR.
- IDLE:
  - `pc_we` loads `pc <= pc_next`.
  - `fetch_start` latches the fetch address, clears `ir_valid`, and moves to FETCH.
  - The fetch address is `pc_we ? pc_next : pc`. When both are asserted in the same cycle, the new target is fetched.
- Alignment check in IDLE: if `fetch_start` is asserted and the fetch address has `[1:0] != 0`, go to ERR with `err_code = 1`. No request is issued.
- FETCH:
  - `imem_req = 1` and `imem_addr` = the latched address.
  - On `imem_ready`: `ir <= imem_rdata`, `pc <= address + 4`, set `ir_valid`, pulse `fetch_done`, return to IDLE.
- Timeout: a wait counter increments each FETCH cycle without `imem_ready`. When it reaches `TIMEOUT`, go to ERR with `err_code = 2`. The counter clears on entering FETCH.
- ERR:
  - `imem_req = 0`, `err = 1`, and `ir_valid` stays 0.
  - `fetch_start` and `pc_we` are ignored.
  - Only `rst` exits ERR.
- `pc_we` and `fetch_start` are ignored while in FETCH.
- `pc` arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0.
- `imm_signed` is 0 for `op` ∈ {0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui}, and 1 otherwise.
- All field outputs are combinational from `ir` and `pc`.

## Timing
- Reset values:
  - `pc = RESET_PC`, `ir = 0`, `ir_valid = 0`, `fetch_done = 0`.
  - `imem_req = 0`, `err = 0`, `err_code = 0`, state IDLE.
  - All field outputs therefore read 0, except `imm_signed = 1` and `pc_hi4 = RESET_PC[31:28]`.
- Request timing: `fetch_start` in cycle 0 makes `imem_req` high in cycle 1.
- Zero-wait memory (ready in cycle 1): `ir`, `ir_valid`, `fetch_done`, and the new `pc` are visible in cycle 2.
- General latency: `imem_ready` in cycle k gives the updated outputs in cycle k+1, with the state back in IDLE. A `fetch_start` in cycle k+1 is accepted.
- Timeout: `TIMEOUT` consecutive FETCH cycles without ready give `err` high on the following cycle, with `imem_req` low in that same cycle.
- `fetch_done` is high for exactly one cycle per successful fetch.
- Asynchronous `rst` mid-FETCH drops `imem_req` immediately. A late `imem_ready` after reset is ignored.

## Structure
- Shared package `cpu54_pkg`:
  - state enum `fetch_state_t`
  - opcode constants `OP_ANDI`, `OP_ORI`, `OP_XORI`, `OP_LUI`
  - `ERR_NONE`, `ERR_MISALIGN`, `ERR_TIMEOUT`
  - default reset vector `PC_RESET_DEFAULT`
- One sub-module, `ir_fields`: the combinational splitter from `ir` to the field outputs plus `imm_signed`. The extender select decode lives in one place.
- FSM, PC register, IR register, and wait counter stay in `instr_fetch`.

## Test plan
- Reset, then `fetch_start` with memory returning 0x3C01_1234 ready in cycle 1 → `ir_valid` and `fetch_done` in cycle 2; `pc = 0x0040_0004`; `op = 0x0F`; `rt = 1`; `imm16 = 0x1234`; `imm_signed = 0`.
- Fetch 0x2021_FFFF (addi) with ready after 5 wait cycles → `imem_addr` stable through the wait; `imm_signed = 1`; `fetch_done` is a single pulse.
- `pc_we` with `pc_next = 0x0040_0100` and `fetch_start` in the same cycle → `imem_addr = 0x0040_0100`; `pc = 0x0040_0104` afterward.
- `pc_we` with `pc_next = 0x0040_0102`, then `fetch_start` → no `imem_req`; `err = 1`, `err_code = 1`; later `fetch_start` ignored.
- `TIMEOUT = 4`, memory never ready → `imem_req` high 4 cycles, then `err_code = 2` and `imem_req` low; `rst` restores `pc = RESET_PC` and `err = 0`.
- `pc_we` with 0xFFFF_FFFC, then fetch → `pc` wraps to 0x0000_0000; `pc_hi4` goes from 0xF to 0x0.

Source files
------------

// File: rtl/cpu54_pkg.sv
// Shared types and constants for the cpu54 multicycle datapath blocks.
package cpu54_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/ir_fields.sv
// Splits the instruction register into its MIPS fields and decodes the
// immediate extender's signed/unsigned select.
module ir_fields
    import cpu54_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] index26,
    output logic        imm_signed
);

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign shamt   = ir[10:6];
    assign func    = ir[5:0];
    assign imm16   = ir[15:0];
    assign index26 = ir[25:0];

    // Logical immediates and lui take a zero-extended immediate.
    always_comb begin
        imm_signed = 1'b1;
        case (ir[31:26])
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: imm_signed = 1'b0;
            default:                          imm_signed = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: PC, fetch handshake with instruction memory,
// IR latch, misalignment and timeout detection.
module instr_fetch
    import cpu54_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        fetch_done,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] index26,
    output logic [3:0]  pc_hi4,
    output logic        imm_signed,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t     state, state_nxt;
    logic [31:0]      fetch_addr;
    logic [31:0]      start_addr;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept, load_ir, misalign, timeout_hit;

    // A same-cycle PC write redirects the fetch to the new target.
    assign start_addr = pc_we ? pc_next : pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        load_ir     = 1'b0;
        misalign    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_start) begin
                    if (start_addr[1:0] != 2'b00) begin
                        misalign  = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    load_ir   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_ERR;
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request is a pure state decode so an async reset drops it immediately.
    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = fetch_addr;
    assign err       = (state == ST_ERR);
    assign pc_plus4  = pc + 32'd4;
    assign pc_hi4    = pc[31:28];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            fetch_addr <= 32'd0;
            ir         <= 32'd0;
            ir_valid   <= 1'b0;
            fetch_done <= 1'b0;
            wait_cnt   <= '0;
            err_code   <= ERR_NONE;
        end else begin
            fetch_done <= load_ir;
            if (state == ST_IDLE && pc_we)
                pc <= pc_next;
            if (state == ST_IDLE && fetch_start)
                ir_valid <= 1'b0;
            if (accept) begin
                fetch_addr <= start_addr;
                wait_cnt   <= '0;
            end
            if (state == ST_FETCH && !imem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (load_ir) begin
                ir       <= imem_rdata;
                ir_valid <= 1'b1;
                pc       <= fetch_addr + 32'd4;
            end
            if (misalign)
                err_code <= ERR_MISALIGN;
            if (timeout_hit)
                err_code <= ERR_TIMEOUT;
        end
    end

    ir_fields u_ir_fields (
        .ir         (ir),
        .op         (op),
        .func       (func),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm16      (imm16),
        .index26    (index26),
        .imm_signed (imm_signed)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: main instance (TIMEOUT=8) plus a
// never-ready instance (TIMEOUT=4) for the timeout path.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_we = 1'b0;
    logic [31:0] pc_next = 32'd0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic        t4_ready = 1'b0;

    logic        imem_req, ir_valid, fetch_done, imm_signed, err;
    logic [31:0] imem_addr, pc, pc_plus4, ir;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [3:0]  pc_hi4;
    logic [1:0]  err_code;

    logic        t4_req, t4_ir_valid, t4_done, t4_imm_signed, t4_err;
    logic [31:0] t4_addr, t4_pc, t4_pc_plus4, t4_ir;
    logic [5:0]  t4_op, t4_func;
    logic [4:0]  t4_rs, t4_rt, t4_rd, t4_shamt;
    logic [15:0] t4_imm16;
    logic [25:0] t4_index26;
    logic [3:0]  t4_pc_hi4;
    logic [1:0]  t4_err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_we(pc_we),
        .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc),
        .pc_plus4(pc_plus4), .ir(ir), .ir_valid(ir_valid),
        .fetch_done(fetch_done), .op(op), .func(func), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .imm16(imm16), .index26(index26),
        .pc_hi4(pc_hi4), .imm_signed(imm_signed), .err(err),
        .err_code(err_code)
    );

    instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT(4)) u_dut_t4 (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_we(pc_we),
        .pc_next(pc_next), .imem_req(t4_req), .imem_addr(t4_addr),
        .imem_rdata(imem_rdata), .imem_ready(t4_ready), .pc(t4_pc),
        .pc_plus4(t4_pc_plus4), .ir(t4_ir), .ir_valid(t4_ir_valid),
        .fetch_done(t4_done), .op(t4_op), .func(t4_func), .rs(t4_rs),
        .rt(t4_rt), .rd(t4_rd), .shamt(t4_shamt), .imm16(t4_imm16),
        .index26(t4_index26), .pc_hi4(t4_pc_hi4),
        .imm_signed(t4_imm_signed), .err(t4_err), .err_code(t4_err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_plus4", pc_plus4, 32'h0040_0004);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_done", fetch_done, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_imm_signed", imm_signed, 1);
        chk("rst_op", op, 0);
        chk("rst_pc_hi4", pc_hi4, 0);

        // zero-wait lui fetch
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0040_0000);
        imem_ready = 1'b1;
        imem_rdata = 32'h3C01_1234;
        tick();
        imem_ready = 1'b0;
        chk("t1_ir_valid", ir_valid, 1);
        chk("t1_done", fetch_done, 1);
        chk("t1_ir", ir, 32'h3C01_1234);
        chk("t1_pc", pc, 32'h0040_0004);
        chk("t1_op", op, 6'h0F);
        chk("t1_rt", rt, 1);
        chk("t1_imm16", imm16, 16'h1234);
        chk("t1_imm_signed", imm_signed, 0);
        chk("t1_req_low", imem_req, 0);
        tick();
        chk("t1_done_pulse", fetch_done, 0);

        // addi with 5 wait cycles
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_wait_req", imem_req, 1);
            chk("t2_wait_addr", imem_addr, 32'h0040_0004);
            chk("t2_wait_done", fetch_done, 0);
            tick();
        end
        chk("t2_req_at_ready", imem_req, 1);
        imem_ready = 1'b1;
        imem_rdata = 32'h2021_FFFF;
        tick();
        imem_ready = 1'b0;
        chk("t2_done", fetch_done, 1);
        chk("t2_ir_valid", ir_valid, 1);
        chk("t2_imm_signed", imm_signed, 1);
        chk("t2_pc", pc, 32'h0040_0008);
        chk("t2_rs", rs, 1);
        chk("t2_rt", rt, 1);
        chk("t2_imm16", imm16, 16'hFFFF);
        chk("t2_err", err, 0);
        tick();
        chk("t2_done_pulse", fetch_done, 0);

        // pc_we and fetch_start together
        pc_we = 1'b1;
        pc_next = 32'h0040_0100;
        fetch_start = 1'b1;
        tick();
        pc_we = 1'b0;
        fetch_start = 1'b0;
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'h0040_0100);
        imem_ready = 1'b1;
        imem_rdata = 32'h0123_4020;
        tick();
        imem_ready = 1'b0;
        chk("t3_pc", pc, 32'h0040_0104);
        chk("t3_rs", rs, 9);
        chk("t3_rt", rt, 3);
        chk("t3_rd", rd, 8);
        chk("t3_shamt", shamt, 0);
        chk("t3_func", func, 6'h20);
        chk("t3_index26", index26, 26'h123_4020);

        // misaligned target
        pc_we = 1'b1;
        pc_next = 32'h0040_0102;
        tick();
        pc_we = 1'b0;
        chk("t4_pc", pc, 32'h0040_0102);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t4_req", imem_req, 0);
        chk("t4_err", err, 1);
        chk("t4_err_code", err_code, 1);
        chk("t4_ir_valid", ir_valid, 0);
        fetch_start = 1'b1;
        pc_we = 1'b1;
        pc_next = 32'h0040_0200;
        tick();
        fetch_start = 1'b0;
        pc_we = 1'b0;
        chk("t4_ignored_req", imem_req, 0);
        chk("t4_ignored_pc", pc, 32'h0040_0102);
        chk("t4_sticky", err, 1);

        // async reset clears the error
        rst = 1'b1;
        #1;
        chk("t5_async_pc", pc, RST_PC);
        chk("t5_async_err", err, 0);
        chk("t5_async_code", err_code, 0);
        tick();
        rst = 1'b0;
        tick();

        // pc wrap
        pc_we = 1'b1;
        pc_next = 32'hFFFF_FFFC;
        tick();
        pc_we = 1'b0;
        chk("t6_hi4_before", pc_hi4, 4'hF);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        imem_rdata = 32'h3000_00FF;
        tick();
        imem_ready = 1'b0;
        chk("t6_pc_wrap", pc, 32'h0000_0000);
        chk("t6_hi4_after", pc_hi4, 4'h0);
        chk("t6_andi_unsigned", imm_signed, 0);

        // async reset mid-fetch, late ready ignored
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t7_req", imem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_req_drop", imem_req, 0);
        tick();
        rst = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ready = 1'b0;
        chk("t7_late_valid", ir_valid, 0);
        chk("t7_late_done", fetch_done, 0);
        chk("t7_late_pc", pc, RST_PC);
        chk("t7_late_ir", ir, 32'd0);

        // timeout on the TIMEOUT=4 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t8_req_high", t4_req, 1);
            chk("t8_no_err", t4_err, 0);
            tick();
        end
        chk("t8_req_low", t4_req, 0);
        chk("t8_err", t4_err, 1);
        chk("t8_err_code", t4_err_code, 2);
        chk("t8_ir_valid", t4_ir_valid, 0);
        rst = 1'b1;
        #1;
        chk("t8_rst_pc", t4_pc, RST_PC);
        chk("t8_rst_err", t4_err, 0);
        chk("t8_rst_code", t4_err_code, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
